// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Opcode encodings shared by the ALU slice and the registered top.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_ADD  = 3'd2;
  localparam op_t OP_XOR  = 3'd3;
  localparam op_t OP_PASS = 3'd4;

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module : alu_bit_slice
// Brief  : One combinational ALU bit: operand inversion, full adder, op mux.
// Rev    : 1.0  initial release
// ============================================================================
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_in,
  input  logic       b_in,
  input  logic       ainv,
  input  logic       binv,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       s,
  output logic       cout
);

  logic w_a;
  logic w_b;
  logic w_sum;

  assign w_a   = a_in ^ ainv;
  assign w_b   = b_in ^ binv;
  assign w_sum = w_a ^ w_b ^ cin;
  // Carry always comes from the adder, whatever op is selected.
  assign cout  = (w_a & w_b) | (w_a & cin) | (w_b & cin);

  always_comb begin
    s = 1'b0;
    case (op)
      OP_AND:  s = w_a & w_b;
      OP_OR:   s = w_a | w_b;
      OP_ADD:  s = w_sum;
      OP_XOR:  s = w_a ^ w_b;
      OP_PASS: s = w_a;
      default: s = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_flow_model_ulda.sv
`default_nettype none
// ============================================================================
// Module : data_flow_model_ulda
// Brief  : Registered WIDTH-bit ALU built from a ripple chain of bit slices.
// Rev    : 1.0  initial release
// ============================================================================
module data_flow_model_ulda
  import alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ainv,
  input  logic             Binv,
  input  logic             Cinv,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_c[0] = Cinv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a_in (A[i]),
      .b_in (B[i]),
      .ainv (Ainv),
      .binv (Binv),
      .cin  (w_c[i]),
      .op   (op),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_cout <= w_c[WIDTH];
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_data_flow_model_ulda.sv
`default_nettype none
// ============================================================================
// Module : tb_data_flow_model_ulda
// Brief  : Directed vector bench for 1-bit and 8-bit ALU instances.
// Rev    : 1.0  initial release
// ============================================================================
module tb_data_flow_model_ulda;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ainv;
    logic       binv;
    logic       cinv;
    logic [2:0] op;
    logic [7:0] s;
    logic       cout;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, ainv1, binv1, cinv1;
  logic [2:0] op1;
  logic       s1, cout1;
  logic [7:0] a8, b8;
  logic       ainv8, binv8, cinv8;
  logic [2:0] op8;
  logic [7:0] s8;
  logic       cout8;

  int checks = 0;
  int errors = 0;

  vec_t v1[5];
  vec_t v8[10];

  data_flow_model_ulda #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Ainv(ainv1), .Binv(binv1),
    .Cinv(cinv1), .op(op1), .S(s1), .Cout(cout1)
  );

  data_flow_model_ulda #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Ainv(ainv8), .Binv(binv8),
    .Cinv(cinv8), .op(op8), .S(s8), .Cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk1(input string nm, input logic es, input logic ec);
    checks++;
    if (s1 !== es || cout1 !== ec) begin
      errors++;
      $display("FAIL w1 %s: got S=%b Cout=%b, required S=%b Cout=%b", nm, s1, cout1, es, ec);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] es, input logic ec);
    checks++;
    if (s8 !== es || cout8 !== ec) begin
      errors++;
      $display("FAIL w8 %s: got S=%h Cout=%b, required S=%h Cout=%b", nm, s8, cout8, es, ec);
    end
  endtask

  task automatic drive8(input vec_t v);
    a8 = v.a; b8 = v.b; ainv8 = v.ainv; binv8 = v.binv; cinv8 = v.cinv; op8 = v.op;
  endtask

  initial begin
    //       a      b      ai  bi  ci  op    s      cout  name
    v1[0] = '{8'h1, 8'h0, 1, 1, 0, 3'd0, 8'h0, 0, "nor_and"};
    v1[1] = '{8'h0, 8'h1, 1, 1, 0, 3'd1, 8'h1, 0, "nand_or"};
    v1[2] = '{8'h1, 8'h1, 0, 0, 1, 3'd2, 8'h1, 1, "add_full"};
    v1[3] = '{8'h0, 8'h0, 0, 0, 1, 3'd3, 8'h0, 0, "xor_cin"};
    v1[4] = '{8'h1, 8'h1, 1, 0, 1, 3'd4, 8'h0, 1, "pass_inv"};

    v8[0] = '{8'h05, 8'h07, 0, 1, 1, 3'd2, 8'hFE, 0, "sub_5_7"};
    v8[1] = '{8'h05, 8'h07, 0, 1, 1, 3'd7, 8'h00, 0, "rsv7_sub"};
    v8[2] = '{8'hFF, 8'h01, 0, 0, 0, 3'd2, 8'h00, 1, "add_wrap"};
    v8[3] = '{8'hF0, 8'h3C, 0, 0, 0, 3'd0, 8'h30, 1, "and"};
    v8[4] = '{8'hAA, 8'h55, 0, 0, 0, 3'd3, 8'hFF, 0, "xor"};
    v8[5] = '{8'h0F, 8'h00, 1, 0, 0, 3'd4, 8'hF0, 0, "pass_ainv"};
    v8[6] = '{8'h0C, 8'h0A, 1, 1, 0, 3'd0, 8'hF1, 1, "nor"};
    v8[7] = '{8'h0C, 8'h0A, 1, 1, 0, 3'd1, 8'hF7, 1, "nand"};
    v8[8] = '{8'h80, 8'h80, 0, 0, 0, 3'd5, 8'h00, 1, "rsv5_carry"};
    v8[9] = '{8'h12, 8'h34, 0, 0, 0, 3'd6, 8'h00, 0, "rsv6"};

    rst_n = 1'b0;
    a1 = 0; b1 = 0; ainv1 = 0; binv1 = 0; cinv1 = 0; op1 = 3'd0;
    a8 = 8'hFF; b8 = 8'hFF; ainv8 = 0; binv8 = 0; cinv8 = 1; op8 = 3'd2;
    @(posedge clk); #1;
    chk1("reset", 1'b0, 1'b0);
    chk8("reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a1 = v1[i].a[0]; b1 = v1[i].b[0]; ainv1 = v1[i].ainv; binv1 = v1[i].binv;
      cinv1 = v1[i].cinv; op1 = v1[i].op;
      @(posedge clk); #1;
      chk1(v1[i].name, v1[i].s[0], v1[i].cout);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive8(v8[i]);
      @(posedge clk); #1;
      chk8(v8[i].name, v8[i].s, v8[i].cout);
    end

    // Asynchronous reset between edges, hold while low, clean release.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; ainv8 = 0; binv8 = 0; cinv8 = 1; op8 = 3'd2;
    @(posedge clk); #1;
    chk8("pre_reset", 8'h81, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk8("async_clear", 8'h00, 1'b0);
    @(posedge clk); #1;
    chk8("hold_low", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h33; b8 = 8'h0F; ainv8 = 0; binv8 = 0; cinv8 = 0; op8 = 3'd1;
    #1;
    chk8("no_stale", 8'h00, 1'b0);
    @(posedge clk); #1;
    chk8("first_after_release", 8'h3F, 1'b0);
    @(negedge clk);
    op8 = 3'd2;
    @(posedge clk); #1;
    chk8("second_after_release", 8'h42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
